issue_stage: RTL

//  In-order dispatch/rename stage of the Tomasulo core, directly downstream of the instruction FIFO.

---
 rtl/issue_stage.sv | 139 +++++++++++++
 1 files changed

// File: rtl/issue_stage.sv
// In-order dispatch/rename stage: pops one {pc,instr} per cycle, renames through a
// 16-entry register status table and issues to the ALU, MEM or BR reservation station.
module issue_stage #(
    parameter int TAGW = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ib_empty,
    input  logic [31:0]         ib_data_out,
    output logic                ib_pop,
    input  logic [2:0]          rs_ready,
    input  logic [3*TAGW-1:0]   rs_tag,
    output logic [2:0]          rs_valid,
    output logic [3:0]          is_op,
    output logic [TAGW-1:0]     is_tag,
    output logic [15:0]         is_va,
    output logic [15:0]         is_vb,
    output logic [TAGW-1:0]     is_qa,
    output logic [TAGW-1:0]     is_qb,
    output logic [3:0]          is_imm,
    output logic [15:0]         is_pc,
    input  logic                cdb_valid,
    input  logic [TAGW-1:0]     cdb_tag,
    input  logic [15:0]         cdb_data,
    input  logic                br_done,
    output logic                halted
);

    typedef enum logic [1:0] {S_RUN, S_BR_WAIT, S_HALT} state_t;

    state_t          state_q;
    logic            halted_q;
    logic [15:0]     busy_q;
    logic [TAGW-1:0] src_q [16];
    logic [15:0]     val_q [16];

    logic [3:0]      op, rd, ra, rb;
    logic [2:0]      cls_oh;
    logic            has_rs, wr_rd, is_br, is_hlt, issue;
    logic [TAGW-1:0] tag_sel;

    assign op = ib_data_out[15:12];
    assign rd = ib_data_out[11:8];
    assign ra = ib_data_out[7:4];
    assign rb = ib_data_out[3:0];

    always_comb begin
        cls_oh = 3'b000;
        wr_rd  = 1'b0;
        is_br  = 1'b0;
        is_hlt = 1'b0;
        if (op <= 4'h7) begin
            cls_oh = 3'b001;
            wr_rd  = 1'b1;
        end else if (op == 4'h8) begin
            cls_oh = 3'b010;
            wr_rd  = 1'b1;
        end else if (op == 4'h9) begin
            cls_oh = 3'b010;
        end else if (op == 4'hC || op == 4'hD) begin
            cls_oh = 3'b100;
            is_br  = 1'b1;
        end else if (op == 4'hF) begin
            is_hlt = 1'b1;
        end
    end

    assign has_rs  = |cls_oh;
    assign tag_sel = cls_oh[2] ? rs_tag[3*TAGW-1:2*TAGW] :
                     cls_oh[1] ? rs_tag[2*TAGW-1:TAGW]   : rs_tag[TAGW-1:0];

    // NOP and HALT consume the FIFO head without needing a reservation station slot
    assign issue    = !rst && (state_q == S_RUN) && !ib_empty &&
                      (!has_rs || |(rs_ready & cls_oh));
    assign ib_pop   = issue;
    assign rs_valid = issue ? cls_oh : 3'b000;
    assign is_op    = op;
    assign is_tag   = tag_sel;
    assign is_imm   = rb;
    assign is_pc    = ib_data_out[31:16];
    assign halted   = halted_q;

    // Operand read with same-cycle CDB bypass; register 0 is hardwired to zero
    always_comb begin
        is_va = val_q[ra];
        is_qa = '0;
        if (ra == 4'd0) begin
            is_va = 16'h0000;
        end else if (busy_q[ra]) begin
            if (cdb_valid && cdb_tag == src_q[ra]) is_va = cdb_data;
            else                                   is_qa = src_q[ra];
        end
        is_vb = val_q[rb];
        is_qb = '0;
        if (rb == 4'd0) begin
            is_vb = 16'h0000;
        end else if (busy_q[rb]) begin
            if (cdb_valid && cdb_tag == src_q[rb]) is_vb = cdb_data;
            else                                   is_qb = src_q[rb];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_RUN;
            halted_q <= 1'b0;
            busy_q   <= '0;
            for (int i = 0; i < 16; i++) begin
                src_q[i] <= '0;
                val_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < 16; i++) begin
                if (cdb_valid && busy_q[i] && src_q[i] == cdb_tag) begin
                    val_q[i]  <= cdb_data;
                    busy_q[i] <= 1'b0;
                end
            end
            // A rename in the same cycle wins over the CDB clearing the old producer
            if (issue && wr_rd && rd != 4'd0) begin
                busy_q[rd] <= 1'b1;
                src_q[rd]  <= tag_sel;
            end
            case (state_q)
                S_RUN: begin
                    if (issue && is_br) begin
                        state_q <= S_BR_WAIT;
                    end else if (issue && is_hlt) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end
                end
                S_BR_WAIT: if (br_done) state_q <= S_RUN;
                default: ;
            endcase
        end
    end

endmodule
